// File: rtl/demux32_1x32_buf.sv
// Buffered 1-to-N demultiplexer: one valid/ready input steered (or broadcast) into per-lane single-word buffers.
// Latency 1 cycle input->lane; a lane accepts when empty or draining the same cycle, so each lane sustains full rate.
module demux32_1x32_buf #(
  parameter int WIDTH     = 32,
  parameter int SEL_WIDTH = 5,
  parameter int NUM_OUT   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_WIDTH-1:0]     in_sel,
  input  logic                     in_bcast,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [15:0]              xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} lane_state_t;

  lane_state_t        state_q [NUM_OUT];
  lane_state_t        state_d [NUM_OUT];
  logic [NUM_OUT-1:0] free;
  logic [NUM_OUT-1:0] load;
  logic               xfer;

  // Ready never looks at in_valid; an X select with in_valid low is masked by xfer.
  always_comb begin
    free     = ~out_valid | out_ready;
    in_ready = 1'b0;
    if (!rst) begin
      if (in_bcast) in_ready = &free;
      else          in_ready = free[in_sel];
    end
    xfer = in_valid & in_ready;
  end

  always_comb begin
    load = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      load[k] = xfer & (in_bcast | (in_sel == SEL_WIDTH'(k)));
    end
  end

  always_comb begin
    out_valid = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      state_d[k]   = state_q[k];
      out_valid[k] = (state_q[k] == FULL);
      case (state_q[k])
        EMPTY:   if (load[k]) state_d[k] = FULL;
        FULL:    if (!load[k] && out_ready[k]) state_d[k] = EMPTY;
        default: state_d[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_OUT; k++) state_q[k] <= EMPTY;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) state_q[k] <= state_d[k];
    end
  end

  // Lane data only moves on a load, so a drained lane keeps its last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (load[k]) out_data[k*WIDTH +: WIDTH] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       xfer_cnt <= '0;
    else if (xfer) xfer_cnt <= xfer_cnt + 16'd1;
  end

endmodule
